requant_pipe: RTL

Pipelined, parameterised requantiser that narrows signed fixed-point accumulator words to activation width. It sits between the convolution/accumulate stage and the feature-map writer. It adds per-sample rounding and saturation modes, a two-stage valid/ready pipeline with backpressure, and a saturation-event counter. Mode 0 reproduces plain bit-slice truncation: `Data_out = Data_in[FRAC_SHIFT+OUT_W-1 : FRAC_SHIFT]`, wrap on overflow.

---
 rtl/requant_pipe.sv | 63 ++++++
 1 files changed

// File: rtl/requant_pipe.sv
// requant_pipe: two-stage valid/ready requantiser narrowing signed accumulators with round/saturate modes and a sticky saturation counter
module requant_pipe #(
  parameter int IN_W = 32,
  parameter int OUT_W = 16,
  parameter int FRAC_SHIFT = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat,
  output logic [CNT_W-1:0] sat_cnt,
  input  logic             sat_clr
);
  localparam int QW = IN_W + 1 - FRAC_SHIFT;
  localparam int BS = FRAC_SHIFT > 0 ? FRAC_SHIFT - 1 : 0;
  localparam logic [IN_W:0] BIAS = FRAC_SHIFT > 0 ? (IN_W+1)'(1) << BS : '0;
  logic v1, v2, s1_ready, s2_ready, rnd, sat1, pos_ovf, neg_ovf, nxt_sat;
  logic [IN_W:0] biased;
  logic [QW-1:0] q1;
  logic [QW-OUT_W:0] hi;
  logic [OUT_W-1:0] nxt_data;
  assign s2_ready = !v2 || out_ready;
  assign s1_ready = !v1 || s2_ready;
  assign in_ready = s1_ready && !rst;
  assign out_valid = v2;
  assign rnd = in_mode[0] ^ in_mode[1];
  assign biased = {in_data[IN_W-1], in_data} + (rnd ? BIAS : '0);
  assign hi = q1[QW-1:OUT_W-1];
  assign pos_ovf = !q1[QW-1] && |hi;
  assign neg_ovf = q1[QW-1] && !(&hi);
  assign nxt_sat = sat1 && (pos_ovf || neg_ovf);
  assign nxt_data = !nxt_sat ? q1[OUT_W-1:0] : pos_ovf ? {1'b0, {(OUT_W-1){1'b1}}} : {1'b1, {(OUT_W-1){1'b0}}};
  always_ff @(posedge clk) begin
    if (s1_ready && in_valid) begin
      q1 <= biased[IN_W:FRAC_SHIFT];
      sat1 <= in_mode[1];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      out_data <= '0;
      out_sat <= 1'b0;
      sat_cnt <= '0;
    end else begin
      if (s1_ready) v1 <= in_valid;
      if (s2_ready) v2 <= v1;
      if (s2_ready && v1) begin
        out_data <= nxt_data;
        out_sat <= nxt_sat;
      end
      sat_cnt <= sat_clr ? '0 : (out_valid && out_ready && out_sat && !(&sat_cnt)) ? sat_cnt + CNT_W'(1) : sat_cnt;
    end
  end
endmodule
